output_port_uart_tx: RTL

- Downstream consumer of the CPU output register. On each output-load pulse from the sequence controller it captures the CPU output word into a small FIFO.
- It serializes every buffered word onto a single UART-style Tx line, LSB byte first, 8N1 framing.
- It sits between the CPU top level (OutReg / Output_Ld) and an FPGA pin, so program output becomes observable without stalling the CPU.

---
 rtl/output_port_uart_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/output_port_uart_tx.sv
// Buffers CPU output words in a small FIFO and shifts them out as 8N1 serial
// frames, least-significant byte first.
module output_port_uart_tx #(
  parameter int DataWidth     = 16,
  parameter int FifoDepthLog2 = 2,
  parameter int ClksPerBit    = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Out_Ld,
  input  logic [DataWidth-1:0]   DIn,
  output logic                   Tx,
  output logic                   Busy,
  output logic                   Empty,
  output logic                   Full,
  output logic [FifoDepthLog2:0] Count,
  output logic                   Overflow
);

  localparam int Depth    = 1 << FifoDepthLog2;
  localparam int NumBytes = DataWidth / 8;
  localparam int TimerW   = $clog2(ClksPerBit);
  localparam int ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  localparam logic [TimerW-1:0]      TimerLoad = TimerW'(ClksPerBit - 1);
  localparam logic [ByteW-1:0]       LastByte  = ByteW'(NumBytes - 1);
  localparam logic [FifoDepthLog2:0] DepthCnt  = (FifoDepthLog2 + 1)'(Depth);

  if ((DataWidth % 8) != 0 || DataWidth < 8) begin : g_bad_width
    $error("DataWidth must be a nonzero multiple of 8");
  end
  if (ClksPerBit < 2) begin : g_bad_clks
    $error("ClksPerBit must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DataWidth-1:0]     mem_q [Depth];
  logic [FifoDepthLog2-1:0] wptr_q, rptr_q;
  logic [FifoDepthLog2:0]   count_q, count_d;
  logic                     empty_q, full_q, ovf_q;
  logic                     push, pop, drop;

  state_t                   state_q, state_d;
  logic [TimerW-1:0]        timer_q, timer_d;
  logic [2:0]               bit_q, bit_d;
  logic [ByteW-1:0]         byte_q, byte_d;
  logic [DataWidth-1:0]     shreg_q, shreg_d;
  logic                     tx_q, tx_d;
  logic                     busy_q;

  // A full FIFO still accepts a push on the edge the transmitter pops.
  always_comb begin
    pop     = (state_q == IDLE) && !empty_q;
    push    = Out_Ld && (!full_q || pop);
    drop    = Out_Ld && full_q && !pop;
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (push)
      mem_q[wptr_q] <= DIn;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (drop) ovf_q  <= 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DepthCnt);
    end
  end

  // Tx is computed for the state being entered so the line is a plain flop.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = START;
          shreg_d = mem_q[rptr_q];
          byte_d  = '0;
          timer_d = TimerLoad;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (timer_q == '0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          timer_d = TimerLoad;
          tx_d    = shreg_q[0];
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = TimerLoad;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shreg_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (byte_q != LastByte) begin
            state_d = START;
            byte_d  = byte_q + 1'b1;
            timer_d = TimerLoad;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign Tx       = tx_q;
  assign Busy     = busy_q;
  assign Empty    = empty_q;
  assign Full     = full_q;
  assign Count    = count_q;
  assign Overflow = ovf_q;

endmodule
